// File: rtl/xadac_pkg.sv
// Shared XADAC types plus the vector-register field helpers used by the vreg stage and the units.
package xadac_pkg;

   localparam int unsigned IdWidth      = 4;
   localparam int unsigned Xlen         = 32;
   localparam int unsigned Vlen         = 128;
   localparam int unsigned NrVregs      = 32;
   localparam int unsigned VregIdxWidth = $clog2(NrVregs);

   typedef logic [IdWidth-1:0]      IdT;
   typedef logic [31:0]             InstrT;
   typedef logic [Xlen-1:0]         XlenT;
   typedef logic [Vlen-1:0]         VectorT;
   typedef logic [VregIdxWidth-1:0] VregIdxT;

   function automatic VregIdxT vreg_vs1(input InstrT instr);
      return instr[19:15];
   endfunction

   function automatic VregIdxT vreg_vs2(input InstrT instr);
      return instr[24:20];
   endfunction

   // vd and vs3 share the same field
   function automatic VregIdxT vreg_vd(input InstrT instr);
      return instr[11:7];
   endfunction

endpackage

// File: rtl/xadac_vreg_scoreboard.sv
// Busy-bit scoreboard: per-register busy, per-id pending flag and id->vd table.
// XADAC_VREG_BYPASS_EN hides the register being released this cycle from the hazard query.
module xadac_vreg_scoreboard
   import xadac_pkg::*;
#(
   parameter int unsigned NrVregs = 32,
   parameter int unsigned NrIds   = 2**IdWidth
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    set_en,
   input  IdT      set_id,
   input  VregIdxT set_idx,
   input  logic    clr_en,
   input  IdT      clr_id,
   input  VregIdxT q_vs1,
   input  VregIdxT q_vs2,
   input  VregIdxT q_vs3,
   output logic    clr_valid,
   output VregIdxT clr_idx,
   output logic    haz
);

   logic [NrVregs-1:0] busy_r;
   logic [NrIds-1:0]   pend_r;
   VregIdxT            vd_tab_r [NrIds];
   logic [NrVregs-1:0] busy_eff_s;

   assign clr_valid = clr_en & pend_r[clr_id];
   assign clr_idx   = vd_tab_r[clr_id];

   // Busy view seen by the hazard check
   always_comb begin
      busy_eff_s = busy_r;
`ifdef XADAC_VREG_BYPASS_EN
      if (clr_valid) begin
         busy_eff_s[clr_idx] = 1'b0;
      end else begin
         busy_eff_s = busy_r;
      end
`endif
   end

   assign haz = busy_eff_s[q_vs1] | busy_eff_s[q_vs2] | busy_eff_s[q_vs3];

   // Scoreboard state; the set is written last so it wins over a same-cycle clear
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= '0;
         pend_r <= '0;
         for (int i = 0; i < int'(NrIds); i++) begin
            vd_tab_r[i] <= '0;
         end
      end else begin
         if (clr_valid) begin
            busy_r[clr_idx] <= 1'b0;
         end
         if (clr_en) begin
            pend_r[clr_id] <= 1'b0;
         end
         if (set_en) begin
            busy_r[set_idx]  <= 1'b1;
            pend_r[set_id]   <= 1'b1;
            vd_tab_r[set_id] <= set_idx;
         end
      end
   end

endmodule

// File: rtl/xadac_stage_vreg.sv
// XADAC vector-register issue stage: one-entry holding register, vreg file, RAW scoreboard.
// Optional feature macro XADAC_VREG_BYPASS_EN forwards same-cycle vd responses into operands.
module xadac_stage_vreg
   import xadac_pkg::*;
#(
   parameter int unsigned NrVregs = 32,
   parameter int unsigned NrIds   = 2**IdWidth
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   in_req_valid,
   output logic   in_req_ready,
   input  IdT     in_req_id,
   input  InstrT  in_req_instr,
   input  XlenT   in_req_rs1,
   input  XlenT   in_req_rs2,
   output logic   out_req_valid,
   input  logic   out_req_ready,
   output IdT     out_req_id,
   output InstrT  out_req_instr,
   output XlenT   out_req_rs1,
   output XlenT   out_req_rs2,
   output VectorT out_req_vs1,
   output VectorT out_req_vs2,
   output VectorT out_req_vs3,
   input  logic   out_req_vd_clobber,
   input  logic   unit_resp_valid,
   output logic   unit_resp_ready,
   input  IdT     unit_resp_id,
   input  XlenT   unit_resp_rd,
   input  logic   unit_resp_rd_write,
   input  VectorT unit_resp_vd,
   input  logic   unit_resp_vd_write,
   output logic   core_resp_valid,
   input  logic   core_resp_ready,
   output IdT     core_resp_id,
   output XlenT   core_resp_rd,
   output logic   core_resp_rd_write
);

   logic    hv_r;
   IdT      id_r;
   InstrT   instr_r;
   XlenT    rs1_r;
   XlenT    rs2_r;
   VectorT  vreg_r [NrVregs];
   logic    haz_s;
   logic    out_hs_s;
   logic    resp_hs_s;
   logic    clr_valid_s;
   VregIdxT clr_idx_s;
   VregIdxT vs1_s;
   VregIdxT vs2_s;
   VregIdxT vd_s;

   assign vs1_s = vreg_vs1(instr_r);
   assign vs2_s = vreg_vs2(instr_r);
   assign vd_s  = vreg_vd(instr_r);

   assign out_req_valid = hv_r & ~haz_s;
   assign out_hs_s      = out_req_valid & out_req_ready;
   assign in_req_ready  = ~hv_r | out_hs_s;
   assign out_req_id    = id_r;
   assign out_req_instr = instr_r;
   assign out_req_rs1   = rs1_r;
   assign out_req_rs2   = rs2_r;

   assign resp_hs_s          = unit_resp_valid & core_resp_ready;
   assign unit_resp_ready    = core_resp_ready;
   assign core_resp_valid    = unit_resp_valid;
   assign core_resp_id       = unit_resp_id;
   assign core_resp_rd       = unit_resp_rd;
   assign core_resp_rd_write = unit_resp_rd_write;

   xadac_vreg_scoreboard #(
      .NrVregs (NrVregs),
      .NrIds   (NrIds)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set_en    (out_hs_s & out_req_vd_clobber),
      .set_id    (id_r),
      .set_idx   (vd_s),
      .clr_en    (resp_hs_s),
      .clr_id    (unit_resp_id),
      .q_vs1     (vs1_s),
      .q_vs2     (vs2_s),
      .q_vs3     (vd_s),
      .clr_valid (clr_valid_s),
      .clr_idx   (clr_idx_s),
      .haz       (haz_s)
   );

`ifdef XADAC_VREG_BYPASS_EN
   logic fwd_s;
   assign fwd_s = resp_hs_s & unit_resp_vd_write;
   assign out_req_vs1 = (fwd_s && (vs1_s == clr_idx_s)) ? unit_resp_vd : vreg_r[vs1_s];
   assign out_req_vs2 = (fwd_s && (vs2_s == clr_idx_s)) ? unit_resp_vd : vreg_r[vs2_s];
   assign out_req_vs3 = (fwd_s && (vd_s  == clr_idx_s)) ? unit_resp_vd : vreg_r[vd_s];
`else
   assign out_req_vs1 = vreg_r[vs1_s];
   assign out_req_vs2 = vreg_r[vs2_s];
   assign out_req_vs3 = vreg_r[vd_s];
`endif

   // Holding register: load on input handshake, release on issue
   always_ff @(posedge clk) begin
      if (rst) begin
         hv_r    <= 1'b0;
         id_r    <= '0;
         instr_r <= 32'd0;
         rs1_r   <= '0;
         rs2_r   <= '0;
      end else if (in_req_valid && in_req_ready) begin
         hv_r    <= 1'b1;
         id_r    <= in_req_id;
         instr_r <= in_req_instr;
         rs1_r   <= in_req_rs1;
         rs2_r   <= in_req_rs2;
      end else if (out_hs_s) begin
         hv_r    <= 1'b0;
      end
   end

   // Register file; the write target comes from the id->vd table
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NrVregs); i++) begin
            vreg_r[i] <= '0;
         end
      end else if (resp_hs_s && unit_resp_vd_write) begin
         vreg_r[clr_idx_s] <= unit_resp_vd;
      end
   end

endmodule

// File: tb/tb_xadac_stage_vreg.sv
// Bench for xadac_stage_vreg: directed scenarios then random traffic against an array-based model.
module tb_xadac_stage_vreg;
   import xadac_pkg::*;

   logic   clk = 1'b0;
   logic   rst;
   logic   in_req_valid, in_req_ready;
   IdT     in_req_id;
   InstrT  in_req_instr;
   XlenT   in_req_rs1, in_req_rs2;
   logic   out_req_valid, out_req_ready;
   IdT     out_req_id;
   InstrT  out_req_instr;
   XlenT   out_req_rs1, out_req_rs2;
   VectorT out_req_vs1, out_req_vs2, out_req_vs3;
   logic   out_req_vd_clobber;
   logic   unit_resp_valid, unit_resp_ready;
   IdT     unit_resp_id;
   XlenT   unit_resp_rd;
   logic   unit_resp_rd_write;
   VectorT unit_resp_vd;
   logic   unit_resp_vd_write;
   logic   core_resp_valid, core_resp_ready;
   IdT     core_resp_id;
   XlenT   core_resp_rd;
   logic   core_resp_rd_write;

   int n_total = 0;
   int n_bad   = 0;

   // reference model state
   bit     m_hv;
   IdT     m_id;
   InstrT  m_instr;
   XlenT   m_rs1, m_rs2;
   bit     m_busy [32];
   bit     m_pend [16];
   int     m_vtab [16];
   VectorT m_vreg [32];
   bit     exp_ov;

   localparam VectorT PatA5 = {16{8'hA5}};

   xadac_stage_vreg dut (
      .clk(clk), .rst(rst),
      .in_req_valid(in_req_valid), .in_req_ready(in_req_ready),
      .in_req_id(in_req_id), .in_req_instr(in_req_instr),
      .in_req_rs1(in_req_rs1), .in_req_rs2(in_req_rs2),
      .out_req_valid(out_req_valid), .out_req_ready(out_req_ready),
      .out_req_id(out_req_id), .out_req_instr(out_req_instr),
      .out_req_rs1(out_req_rs1), .out_req_rs2(out_req_rs2),
      .out_req_vs1(out_req_vs1), .out_req_vs2(out_req_vs2), .out_req_vs3(out_req_vs3),
      .out_req_vd_clobber(out_req_vd_clobber),
      .unit_resp_valid(unit_resp_valid), .unit_resp_ready(unit_resp_ready),
      .unit_resp_id(unit_resp_id), .unit_resp_rd(unit_resp_rd),
      .unit_resp_rd_write(unit_resp_rd_write), .unit_resp_vd(unit_resp_vd),
      .unit_resp_vd_write(unit_resp_vd_write),
      .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
      .core_resp_id(core_resp_id), .core_resp_rd(core_resp_rd),
      .core_resp_rd_write(core_resp_rd_write)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic InstrT mk(input int s1, input int s2, input int d);
      InstrT r;
      r = 32'h0000_0057;
      r[19:15] = s1[4:0];
      r[24:20] = s2[4:0];
      r[11:7]  = d[4:0];
      return r;
   endfunction

   function automatic int fld(input InstrT i, input int lsb);
      return int'((i >> lsb) & 32'd31);
   endfunction

   task automatic model_reset();
      m_hv = 1'b0; m_id = '0; m_instr = 32'd0; m_rs1 = '0; m_rs2 = '0;
      for (int i = 0; i < 32; i++) begin m_busy[i] = 1'b0; m_vreg[i] = '0; end
      for (int i = 0; i < 16; i++) begin m_pend[i] = 1'b0; m_vtab[i] = 0; end
   endtask

   task automatic drv_idle();
      in_req_valid = 1'b0; in_req_id = '0; in_req_instr = 32'd0; in_req_rs1 = '0; in_req_rs2 = '0;
      out_req_ready = 1'b1; out_req_vd_clobber = 1'b0;
      unit_resp_valid = 1'b0; unit_resp_id = '0; unit_resp_rd = '0; unit_resp_rd_write = 1'b0;
      unit_resp_vd = '0; unit_resp_vd_write = 1'b0; core_resp_ready = 1'b1;
   endtask

   task automatic put_req(input int id, input InstrT instr, input XlenT r1, input XlenT r2);
      in_req_valid = 1'b1; in_req_id = IdT'(id); in_req_instr = instr;
      in_req_rs1 = r1; in_req_rs2 = r2;
   endtask

   // compare every DUT output with the model, away from the clock edge
   task automatic sample();
      int a, b, c, w;
      bit haz, rhs, fwd;
      VectorT e1, e2, e3;
      @(negedge clk);
      a = fld(m_instr, 15); b = fld(m_instr, 20); c = fld(m_instr, 7);
      w = m_vtab[unit_resp_id];
      rhs = unit_resp_valid && core_resp_ready;
      haz = m_busy[a] || m_busy[b] || m_busy[c];
      fwd = 1'b0;
`ifdef XADAC_VREG_BYPASS_EN
      if (rhs && m_pend[unit_resp_id])
         haz = (m_busy[a] && a != w) || (m_busy[b] && b != w) || (m_busy[c] && c != w);
      fwd = rhs && unit_resp_vd_write;
`endif
      e1 = (fwd && a == w) ? unit_resp_vd : m_vreg[a];
      e2 = (fwd && b == w) ? unit_resp_vd : m_vreg[b];
      e3 = (fwd && c == w) ? unit_resp_vd : m_vreg[c];
      exp_ov = m_hv && !haz;
      check("out_valid", out_req_valid, exp_ov);
      check("in_ready", in_req_ready, !m_hv || (exp_ov && out_req_ready));
      check("out_id", out_req_id, m_id);
      check("out_instr", out_req_instr, m_instr);
      check("out_rs1", out_req_rs1, m_rs1);
      check("out_rs2", out_req_rs2, m_rs2);
      check("out_vs1", out_req_vs1, e1);
      check("out_vs2", out_req_vs2, e2);
      check("out_vs3", out_req_vs3, e3);
      check("unit_ready", unit_resp_ready, core_resp_ready);
      check("core_valid", core_resp_valid, unit_resp_valid);
      check("core_id", core_resp_id, unit_resp_id);
      check("core_rd", core_resp_rd, unit_resp_rd);
      check("core_rd_wr", core_resp_rd_write, unit_resp_rd_write);
   endtask

   // apply the clock edge to the model
   task automatic advance();
      bit ihs, ohs, rhs;
      int w, c;
      ohs = exp_ov && out_req_ready;
      ihs = in_req_valid && (!m_hv || ohs);
      rhs = unit_resp_valid && core_resp_ready;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (rhs) begin
            w = m_vtab[unit_resp_id];
            if (unit_resp_vd_write) m_vreg[w] = unit_resp_vd;
            if (m_pend[unit_resp_id]) m_busy[w] = 1'b0;
            m_pend[unit_resp_id] = 1'b0;
         end
         if (ohs && out_req_vd_clobber) begin
            c = fld(m_instr, 7);
            m_busy[c] = 1'b1; m_vtab[m_id] = c; m_pend[m_id] = 1'b1;
         end
         if (ihs) begin
            m_hv = 1'b1; m_id = in_req_id; m_instr = in_req_instr;
            m_rs1 = in_req_rs1; m_rs2 = in_req_rs2;
         end else if (ohs) begin
            m_hv = 1'b0;
         end
      end
      #1;
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   initial begin
      drv_idle();
      rst = 1'b1;
      exp_ov = 1'b0;
      model_reset();
      advance();
      advance();
      rst = 1'b0;

      // reset state
      sample();
      check("rst_in_ready", in_req_ready, 1'b1);
      check("rst_out_valid", out_req_valid, 1'b0);
      check("rst_out_instr", out_req_instr, 32'd0);
      advance();

      // basic issue: vs1=1 vs2=2 vd=3, all operands zero
      put_req(1, mk(1, 2, 3), 32'h11, 32'h22);
      step();
      in_req_valid = 1'b0;
      sample();
      check("issue_valid", out_req_valid, 1'b1);
      check("issue_vs1", out_req_vs1, 128'd0);
      check("issue_vs2", out_req_vs2, 128'd0);
      check("issue_vs3", out_req_vs3, 128'd0);
      check("issue_rs1", out_req_rs1, 32'h11);
      advance();

      // RAW on v3: producer id 5, consumer reads vs2=3
      put_req(5, mk(0, 0, 3), 32'h0, 32'h0);
      step();
      out_req_vd_clobber = 1'b1;
      put_req(6, mk(0, 3, 4), 32'h6, 32'h6);
      sample();
      check("clob_issue", out_req_valid, 1'b1);
      advance();
      out_req_vd_clobber = 1'b0;
      in_req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sample();
         check("raw_stall", out_req_valid, 1'b0);
         advance();
      end
      unit_resp_valid = 1'b1; unit_resp_id = IdT'(5); unit_resp_vd_write = 1'b1; unit_resp_vd = PatA5;
      sample();
`ifdef XADAC_VREG_BYPASS_EN
      check("byp_issue", out_req_valid, 1'b1);
      check("byp_vs2", out_req_vs2, PatA5);
`else
      check("resp_cycle_stall", out_req_valid, 1'b0);
`endif
      advance();
      unit_resp_valid = 1'b0; unit_resp_vd_write = 1'b0;
      sample();
`ifdef XADAC_VREG_BYPASS_EN
      check("byp_drained", out_req_valid, 1'b0);
`else
      check("post_resp_issue", out_req_valid, 1'b1);
      check("post_resp_vs2", out_req_vs2, PatA5);
`endif
      advance();

      // downstream back-pressure holds the entry
      put_req(2, mk(8, 9, 10), 32'hAAAA, 32'hBBBB);
      step();
      out_req_ready = 1'b0;
      put_req(3, mk(11, 12, 13), 32'hCCCC, 32'hDDDD);
      for (int i = 0; i < 4; i++) begin
         sample();
         check("hold_valid", out_req_valid, 1'b1);
         check("hold_in_ready", in_req_ready, 1'b0);
         check("hold_id", out_req_id, 4'd2);
         check("hold_rs1", out_req_rs1, 32'hAAAA);
         advance();
      end
      out_req_ready = 1'b1;
      sample();
      check("release_in_ready", in_req_ready, 1'b1);
      advance();
      in_req_valid = 1'b0;
      sample();
      check("next_id", out_req_id, 4'd3);
      advance();

      // core back-pressure stalls the response and keeps v12 busy
      put_req(7, mk(0, 0, 12), 32'h0, 32'h0);
      step();
      in_req_valid = 1'b0; out_req_vd_clobber = 1'b1;
      step();
      out_req_vd_clobber = 1'b0; out_req_ready = 1'b0; core_resp_ready = 1'b0;
      unit_resp_valid = 1'b1; unit_resp_id = IdT'(7); unit_resp_rd = 32'h1234; unit_resp_rd_write = 1'b1;
      put_req(8, mk(12, 0, 1), 32'h0, 32'h0);
      sample();
      check("bp_unit_ready", unit_resp_ready, 1'b0);
      check("bp_core_rd", core_resp_rd, 32'h1234);
      check("bp_core_id", core_resp_id, 4'd7);
      advance();
      in_req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sample();
         check("bp_busy_kept", out_req_valid, 1'b0);
         advance();
      end
      core_resp_ready = 1'b1;
      sample();
      check("bp_unit_ready_hi", unit_resp_ready, 1'b1);
      advance();
      drv_idle();
      out_req_ready = 1'b0;
      sample();
      check("bp_released", out_req_valid, 1'b1);
      advance();
      out_req_ready = 1'b1;
      step();

      // clobber v7 by id 8, then id 9 writing v7 while id 8 responds
      put_req(8, mk(0, 0, 7), 32'h0, 32'h0);
      step();
      out_req_vd_clobber = 1'b1;
      put_req(9, mk(0, 0, 7), 32'h0, 32'h0);
      step();
      in_req_valid = 1'b0;
      unit_resp_valid = 1'b1; unit_resp_id = IdT'(8); unit_resp_vd_write = 1'b1; unit_resp_vd = 128'h77;
      sample();
`ifdef XADAC_VREG_BYPASS_EN
      check("sw_same_cycle", out_req_valid, 1'b1);
      advance();
      unit_resp_valid = 1'b0;
`else
      check("sw_stall", out_req_valid, 1'b0);
      advance();
      unit_resp_valid = 1'b0;
      sample();
      check("sw_issue", out_req_valid, 1'b1);
      advance();
`endif
      out_req_vd_clobber = 1'b0; unit_resp_vd_write = 1'b0;
      put_req(10, mk(7, 0, 1), 32'h0, 32'h0);
      step();
      in_req_valid = 1'b0;
      sample();
      check("set_wins_stall", out_req_valid, 1'b0);
      advance();
      unit_resp_valid = 1'b1; unit_resp_id = IdT'(9);
      step();
      unit_resp_valid = 1'b0;
      step();
      step();

      // reset with a clobber pending and a stalled reader held
      put_req(11, mk(0, 0, 20), 32'h0, 32'h0);
      step();
      out_req_vd_clobber = 1'b1;
      put_req(12, mk(20, 0, 2), 32'h0, 32'h0);
      step();
      out_req_vd_clobber = 1'b0; in_req_valid = 1'b0;
      sample();
      check("pre_rst_stall", out_req_valid, 1'b0);
      advance();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sample();
      check("rst_mid_valid", out_req_valid, 1'b0);
      check("rst_mid_ready", in_req_ready, 1'b1);
      advance();
      put_req(13, mk(20, 0, 2), 32'h0, 32'h0);
      step();
      in_req_valid = 1'b0;
      sample();
      check("post_rst_issue", out_req_valid, 1'b1);
      advance();

      // random traffic on a small register/id window to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         in_req_valid = 1'($urandom_range(0, 1));
         in_req_id = IdT'($urandom_range(0, 3));
         in_req_instr = $urandom;
         in_req_instr[19:15] = 5'($urandom_range(0, 7));
         in_req_instr[24:20] = 5'($urandom_range(0, 7));
         in_req_instr[11:7]  = 5'($urandom_range(0, 7));
         in_req_rs1 = $urandom; in_req_rs2 = $urandom;
         out_req_ready = ($urandom_range(0, 3) != 0);
         out_req_vd_clobber = 1'($urandom_range(0, 1));
         unit_resp_valid = ($urandom_range(0, 2) == 0);
         unit_resp_id = IdT'($urandom_range(0, 3));
         unit_resp_rd = $urandom;
         unit_resp_rd_write = 1'($urandom_range(0, 1));
         unit_resp_vd = {$urandom, $urandom, $urandom, $urandom};
         unit_resp_vd_write = 1'($urandom_range(0, 1));
         core_resp_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
